// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words onto ccff_head and
// packs the bits displaced out of ccff_tail into readback words in the same pass.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 18,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

  localparam logic [PW-1:0]     WPOS_LAST = PW'(WORD_W - 1);
  localparam logic [CW-1:0]     BIT_LAST  = CW'(CHAIN_LEN - 1);
  localparam logic [WORD_W-1:0] MSB_ONE   = {1'b1, {(WORD_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [CW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [PW-1:0]     wpos_q,     wpos_d;
  logic [PW-1:0]     rpos_q,     rpos_d;
  logic [WORD_W-1:0] shreg_q,    shreg_d;
  logic [WORD_W-1:0] rd_shreg_q, rd_shreg_d;
  logic [WORD_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              head_q,     head_d;
  logic              shift_en_q, shift_en_d;

  logic              go;
  logic              rd_stall;
  logic              last_bit;
  logic              cap_wrap;
  logic              cap_last;
  logic              cap_emit;
  logic              issue;
  logic [WORD_W-1:0] rd_word;

  // A bit is issued one cycle before the chain shifts, so capture lags issue by
  // one cycle. The final bit is held back if the in-flight capture completes a
  // word, otherwise two readback words could be emitted back to back.
  always_comb begin
    go       = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    rd_stall = rd_valid_q & ~rd_ready;
    last_bit = (bit_cnt_q == BIT_LAST);
    cap_wrap = shift_en_q & (rpos_q == WPOS_LAST);
    cap_last = shift_en_q & (state_q == S_DRAIN);
    cap_emit = cap_wrap | cap_last;
    issue    = (state_q == S_SHIFT) & ~rd_stall & ~(last_bit & cap_wrap);
    rd_word  = rd_shreg_q | (ccff_tail ? (MSB_ONE >> rpos_q) : '0);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wpos_d     = wpos_q;
    rpos_d     = rpos_q;
    shreg_d    = shreg_q;
    rd_shreg_d = rd_shreg_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    head_d     = head_q;
    shift_en_d = issue;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d    = S_FETCH;
          bit_cnt_d  = '0;
          wpos_d     = '0;
          rpos_d     = '0;
          rd_shreg_d = '0;
        end
      end
      S_FETCH: begin
        if (wr_valid) begin
          shreg_d = wr_data;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (issue) begin
          head_d    = shreg_q[WORD_W-1];
          shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CW'(1);
          wpos_d    = (wpos_q == WPOS_LAST) ? '0 : wpos_q + PW'(1);
          if (last_bit) begin
            state_d = S_DRAIN;
          end else if (wpos_q == WPOS_LAST) begin
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (!shift_en_q && !rd_stall) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end

    // Tail bit is sampled on the same edge the chain shifts (pre-shift value).
    if (shift_en_q) begin
      if (cap_emit) begin
        rd_data_d  = rd_word;
        rd_valid_d = 1'b1;
        rd_shreg_d = '0;
        rpos_d     = '0;
      end else begin
        rd_shreg_d = rd_word;
        rpos_d     = rpos_q + PW'(1);
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      wpos_q     <= '0;
      rpos_q     <= '0;
      shreg_q    <= '0;
      rd_shreg_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wpos_q     <= wpos_d;
      rpos_q     <= rpos_d;
      shreg_q    <= shreg_d;
      rd_shreg_q <= rd_shreg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign wr_ready      = (state_q == S_FETCH);
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = (state_q == S_FETCH) | (state_q == S_SHIFT) | (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration-chain head and consumes the chain tail for one CLB/fle configuration chain (frac_lut4 SRAM plus output-mux memory).
- Accepts bitstream words from the programming controller through a valid/ready handshake. Serializes them MSB-first onto ccff_head and produces ccff_shift_en, which the top level uses to gate prog_clk to the chain.
- Because shifting new bits in pushes the old contents out of ccff_tail, the block packs those tail bits into readback words. This gives a write-and-readback engine for the chain in a single pass.

Parameters:
- CHAIN_LEN, 18, number of flip-flops in the driven chain (16 LUT SRAM + 2 mux SRAM). Must be ≥1.
- WORD_W, 8, width of input and readback words. Must be ≥2.

Ports:
- prog_clk  input  1  programming clock; all state on the rising edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load of CHAIN_LEN bits. Ignored unless the FSM is in IDLE or DONE.
- wr_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- wr_valid  input  1  wr_data valid.
- wr_ready  output  1  word accepted when wr_valid & wr_ready.
- rd_data  output  WORD_W  readback word; first tail bit in bit WORD_W-1.
- rd_valid  output  1  rd_data valid; held stable until accepted.
- rd_ready  input  1  consumer accepts rd_data.
- ccff_head  output  1  registered serial bit into the chain.
- ccff_tail  input  1  serial bit out of the chain.
- ccff_shift_en  output  1  registered; the chain shifts on every prog_clk edge where this is 1.
- busy  output  1  high from the start acceptance until DONE.
- done  output  1  high in DONE until the next start.

Behaviour:
- Reset (async, immediate): state=IDLE. ccff_shift_en=0, ccff_head=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, all counters 0.
- Reset mid-load forces ccff_shift_en low at once. Chain contents are then undefined and the load must be restarted.
- Counters:
  - bit_cnt, 0..CHAIN_LEN-1: total bits shifted.
  - wpos, 0..WORD_W-1: position within the current input word.
  - rpos, 0..WORD_W-1: position within the current readback word.
- States:
  - IDLE: start → FETCH; clears bit_cnt, wpos and rpos; busy=1.
  - FETCH: wr_ready=1. On handshake, load the shift register with wr_data and go to SHIFT. ccff_shift_en stays 0 while waiting; there is no timeout.
  - SHIFT: each cycle in which a shift is allowed:
    - ccff_head is driven with shreg MSB and ccff_shift_en=1 on the next cycle.
    - On that shifting edge, the pre-shift ccff_tail value is captured into rd shreg position WORD_W-1-rpos.
    - bit_cnt++, wpos++, rpos++.
  - Shift allowed only if the readback word is not stalled: rd_valid=0, or rd_valid & rd_ready in the same cycle.
  - When rpos wraps (WORD_W bits captured), rd_data is loaded and rd_valid=1 the next cycle.
  - When wpos wraps and bit_cnt<CHAIN_LEN, go to FETCH.
  - When bit_cnt reaches CHAIN_LEN: the final partial readback word is emitted with unused LSBs zero, then go to DRAIN.
  - Unused LSBs of the final input word are ignored and never shifted.
  - DRAIN: wait until rd_valid is cleared by a handshake, then go to DONE.
  - DONE: done=1, busy=0. start → FETCH, same as from IDLE.
- Exactly CHAIN_LEN cycles have ccff_shift_en=1 per load.
- Number of words per load, both directions: ceil(CHAIN_LEN/WORD_W).
- Latency: the first ccff_shift_en=1 occurs 2 cycles after the first wr handshake.
- Stalls: while the FSM waits in FETCH or on rd backpressure, ccff_shift_en=0 and ccff_head holds its value.
- start during busy is ignored.
- Tail timing: tail bit k of a load is the bit that was at chain position CHAIN_LEN-1-k before the load, so the oldest-shifted bit comes out first. Load N+1 therefore reads back exactly the bits written by load N, in the same order.

Test Plan:
- Reset mid-SHIFT (bit_cnt=9): drop prog_reset_n → ccff_shift_en=0 and all outputs at reset values in the same cycle. A new start then completes with 18 shift cycles.
- CHAIN_LEN=18, WORD_W=8, chain model initialized to all 0. start, then words 0xA5, 0x3C, 0xC0 → ccff_head sequence on shift edges is 1010_0101_0011_1100_11. Exactly 18 shift_en pulses. Readback 0x00, 0x00, 0x00. done=1.
- Second load with 0xFF, 0xFF, 0xC0 → rd_data 0xA5, 0x3C, 0xC0, i.e. the previous load read back with the final word's 6 LSBs zero.
- wr_valid deasserted for 5 cycles between words → ccff_shift_en=0 for those cycles. Head sequence and readback are unchanged, with no extra shift pulses.
- rd_ready held low for 4 cycles after the first rd_valid → shifting stops after at most 1 further bit. rd_data is held stable, and the total shift count is still 18.
- start pulsed during SHIFT → ignored, bit_cnt is not cleared. start in DONE → a new load begins and wr_ready rises the next cycle.
